// File: rtl/mem_arbiter.sv
// Shared main-memory port arbiter for the I-cache and D-cache miss paths.
// D-cache has priority; the I-cache is forced in after MAX_STREAK D grants.
module mem_arbiter #(
    parameter int MEM_LAT    = 4,
    parameter int MAX_STREAK = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_done,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    localparam logic [3:0] LatInit   = 4'(MEM_LAT);
    localparam logic [3:0] StreakMax = 4'(MAX_STREAK);

    state_t     state;
    logic       ownerD;
    logic       wrLat;
    logic [3:0] latCnt;
    logic [3:0] streak;

    logic anyReq;
    logic grantI;
    logic ownerReq;

    assign anyReq   = i_req | d_req;
    assign grantI   = i_req & (~d_req | (streak == StreakMax));
    assign ownerReq = ownerD ? d_req : i_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ownerD    <= 1'b0;
            wrLat     <= 1'b0;
            latCnt    <= 4'd0;
            streak    <= 4'd0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 16'h0;
            mem_wdata <= 16'h0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    if (anyReq) begin
                        state  <= ISSUE;
                        ownerD <= ~grantI;
                        if (grantI) begin
                            wrLat     <= 1'b0;
                            mem_rd    <= 1'b1;
                            mem_wr    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= 16'h0;
                            streak    <= 4'd0;
                        end else begin
                            wrLat     <= d_wr;
                            mem_rd    <= ~d_wr;
                            mem_wr    <= d_wr;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wr ? d_wdata : 16'h0;
                            // Count D wins only while I is actually waiting
                            if (!i_req)
                                streak <= 4'd0;
                            else if (streak != StreakMax)
                                streak <= streak + 4'd1;
                        end
                    end
                end
                ISSUE: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    latCnt <= LatInit;
                    state  <= WAIT;
                    i_done <= (LatInit == 4'd1) && !ownerD;
                    d_done <= (LatInit == 4'd1) && ownerD;
                end
                WAIT: begin
                    latCnt <= latCnt - 4'd1;
                    // done is registered one cycle ahead of the lat_cnt==1 cycle
                    i_done <= (latCnt == 4'd2) && !ownerD;
                    d_done <= (latCnt == 4'd2) && ownerD;
                    if (latCnt == 4'd1) begin
                        state     <= IDLE;
                        mem_addr  <= 16'h0;
                        mem_wdata <= 16'h0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata = i_done ? mem_rdata : 16'h0;
    assign d_rdata = (d_done && !wrLat) ? mem_rdata : 16'h0;
    assign err     = (state != IDLE) && !ownerReq;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single transactions, contention,
// reset abort, protocol error and a MEM_LAT=1 build.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done, mem_rd, mem_wr, err;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        i_req2, d_req2, d_wr2;
    logic [15:0] i_addr2, d_addr2, d_wdata2;
    logic        i_done2, d_done2, mem_rd2, mem_wr2, err2;
    logic [15:0] i_rdata2, d_rdata2, mem_addr2, mem_wdata2, mem_rdata2;

    int nChecks = 0;
    int nErrors = 0;

    mem_arbiter #(.MEM_LAT(4), .MAX_STREAK(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
    );

    mem_arbiter #(.MEM_LAT(1), .MAX_STREAK(3)) dut2 (
        .clk(clk), .rst(rst),
        .i_req(i_req2), .i_addr(i_addr2), .i_done(i_done2), .i_rdata(i_rdata2),
        .d_req(d_req2), .d_wr(d_wr2), .d_addr(d_addr2), .d_wdata(d_wdata2),
        .d_done(d_done2), .d_rdata(d_rdata2),
        .mem_rd(mem_rd2), .mem_wr(mem_wr2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .err(err2)
    );

    function automatic logic [15:0] memVal(input logic [15:0] a);
        return (a == 16'h0040) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    // Fixed-latency memory models; data is garbage outside the valid cycle
    logic        vld[4];
    logic [15:0] adr[4];
    logic        v2;
    logic [15:0] a2;

    initial begin
        for (int k = 0; k < 4; k++) begin
            vld[k] = 1'b0;
            adr[k] = 16'h0;
        end
        v2 = 1'b0;
        a2 = 16'h0;
    end

    always @(posedge clk) begin
        vld[0] <= mem_rd;
        adr[0] <= mem_addr;
        for (int k = 1; k < 4; k++) begin
            vld[k] <= vld[k-1];
            adr[k] <= adr[k-1];
        end
        v2 <= mem_rd2;
        a2 <= mem_addr2;
    end

    assign mem_rdata  = vld[3] ? memVal(adr[3]) : 16'hDEAD;
    assign mem_rdata2 = v2 ? memVal(a2) : 16'hDEAD;

    task automatic chk1(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkAllZero(input string tag);
        chk1({tag, "_i_done"}, i_done, 1'b0);
        chk1({tag, "_d_done"}, d_done, 1'b0);
        chk16({tag, "_i_rdata"}, i_rdata, 16'h0);
        chk16({tag, "_d_rdata"}, d_rdata, 16'h0);
        chk1({tag, "_mem_rd"}, mem_rd, 1'b0);
        chk1({tag, "_mem_wr"}, mem_wr, 1'b0);
        chk16({tag, "_mem_addr"}, mem_addr, 16'h0);
        chk16({tag, "_mem_wdata"}, mem_wdata, 16'h0);
        chk1({tag, "_err"}, err, 1'b0);
    endtask

    typedef struct {
        logic        isD;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] expData;
    } txn_t;

    txn_t tbl[5];

    task automatic runTxn(input txn_t t);
        step();
        if (t.isD) begin
            d_req = 1'b1; d_wr = t.wr; d_addr = t.addr; d_wdata = t.wdata;
        end else begin
            i_req = 1'b1; i_addr = t.addr;
        end
        #1;
        chk1("idle_rd", mem_rd, 1'b0);
        chk1("idle_wr", mem_wr, 1'b0);
        step();
        chk1("issue_rd", mem_rd, !t.wr);
        chk1("issue_wr", mem_wr, t.wr);
        chk16("issue_addr", mem_addr, t.addr);
        if (t.wr) chk16("issue_wdata", mem_wdata, t.wdata);
        for (int c = 2; c <= 4; c++) begin
            step();
            chk1("wait_i_done", i_done, 1'b0);
            chk1("wait_d_done", d_done, 1'b0);
            chk1("wait_rd", mem_rd, 1'b0);
            chk1("wait_wr", mem_wr, 1'b0);
            chk1("wait_err", err, 1'b0);
        end
        step();
        chk1("done_i", i_done, !t.isD);
        chk1("done_d", d_done, t.isD);
        if (t.isD) begin
            chk16("d_rdata", d_rdata, t.expData);
            chk16("i_rdata_other", i_rdata, 16'h0);
        end else begin
            chk16("i_rdata", i_rdata, t.expData);
            chk16("d_rdata_other", d_rdata, 16'h0);
        end
        step();
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        chk1("post_i_done", i_done, 1'b0);
        chk1("post_d_done", d_done, 1'b0);
        chk16("post_addr", mem_addr, 16'h0);
    endtask

    initial begin
        logic        whoD[8];
        int          whenA[8];
        int          n;
        logic [7:0]  expPat;

        tbl[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1234};
        tbl[1] = '{1'b1, 1'b1, 16'h0100, 16'hBEEF, 16'h0000};
        tbl[2] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'hA7A5};
        tbl[3] = '{1'b0, 1'b0, 16'h1F00, 16'h0000, 16'hBAA5};
        tbl[4] = '{1'b1, 1'b0, 16'h0123, 16'hC0DE, 16'hA486};

        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
        i_req2 = 1'b0; d_req2 = 1'b0; d_wr2 = 1'b0;
        i_addr2 = 16'h0; d_addr2 = 16'h0; d_wdata2 = 16'h0;

        repeat (3) step();
        chkAllZero("reset");
        chk1("reset_done2", d_done2, 1'b0);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) runTxn(tbl[k]);

        // Contention: both held, expect D,D,D,I,D,D,D,I every 6 cycles
        for (int k = 0; k < 8; k++) begin
            whoD[k] = 1'b0;
            whenA[k] = -1;
        end
        n = 0;
        step();
        i_req = 1'b1; i_addr = 16'h0040;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
        #1;
        for (int c = 0; c < 48; c++) begin
            if (c > 0) step();
            chk1("cont_err", err, 1'b0);
            if ((i_done || d_done) && n < 8) begin
                whoD[n] = d_done;
                whenA[n] = c;
                n++;
                if (d_done) chk16("cont_d_rdata", d_rdata, 16'hA7A5);
                else chk16("cont_i_rdata", i_rdata, 16'h1234);
            end
        end
        step();
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        expPat = 8'b0111_0111;
        for (int k = 0; k < 8; k++) begin
            chk1("cont_order", whoD[k], expPat[k]);
            chk16("cont_cycle", whenA[k][15:0], 16'(5 + 6 * k));
        end

        // Reset two cycles after ISSUE abandons the transaction
        step();
        i_req = 1'b1; i_addr = 16'h0300;
        #1;
        step();
        chk1("abort_issue", mem_rd, 1'b1);
        step();
        step();
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        i_req = 1'b0;
        #1;
        chkAllZero("abort");
        for (int c = 0; c < 4; c++) begin
            step();
            chk1("abort_no_done", i_done, 1'b0);
        end
        runTxn(tbl[0]);

        // Owner drops d_req mid-WAIT
        step();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
        #1;
        step();
        chk1("perr_issue", err, 1'b0);
        step();
        step();
        d_req = 1'b0;
        #1;
        chk1("perr_pulse", err, 1'b1);
        step();
        d_req = 1'b1;
        #1;
        chk1("perr_clear", err, 1'b0);
        step();
        chk1("perr_done", d_done, 1'b1);
        chk16("perr_rdata", d_rdata, 16'hA7A5);
        step();
        d_req = 1'b0;
        #1;
        chk1("perr_post", d_done, 1'b0);

        // MEM_LAT=1 build: done two cycles after the request
        step();
        d_req2 = 1'b1; d_wr2 = 1'b0; d_addr2 = 16'h0123;
        #1;
        chk1("lat1_t0_done", d_done2, 1'b0);
        step();
        chk1("lat1_issue_rd", mem_rd2, 1'b1);
        chk16("lat1_issue_addr", mem_addr2, 16'h0123);
        chk1("lat1_t1_done", d_done2, 1'b0);
        step();
        chk1("lat1_done", d_done2, 1'b1);
        chk16("lat1_rdata", d_rdata2, 16'hA486);
        step();
        d_req2 = 1'b0;
        #1;
        chk1("lat1_post", d_done2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
